// File: rtl/ld_pkg.sv
// Shared load-unit definitions: funct3 encodings, access-size decode and the FSM state type.
package ld_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_WAIT0,
        ST_ISSUE1,
        ST_WAIT1,
        ST_RESP
    } ld_state_e;

    // Access size in bytes.
    function automatic logic [3:0] ld_size(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: return 4'd1;
            F3_LH, F3_LHU: return 4'd2;
            F3_LW, F3_LWU: return 4'd4;
            default:       return 4'd8;
        endcase
    endfunction

    function automatic logic ld_illegal(input logic [2:0] funct3, input int xlen);
        return (funct3 == F3_ILL) ||
               ((xlen == 32) && ((funct3 == F3_LD) || (funct3 == F3_LWU)));
    endfunction

    // True when the field crosses into the next bus word.
    function automatic logic ld_split(input int off, input logic [2:0] funct3, input int nb);
        return (off + int'(ld_size(funct3))) > nb;
    endfunction

endpackage

// File: rtl/ld_extract.sv
// Combinational field extraction: shifts the two-beat window down by the byte offset and
// sign- or zero-extends the selected B/H/W/D field to XLEN.
module ld_extract
    import ld_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] beat0,
    input  logic [XLEN-1:0] beat1,
    input  logic [OW-1:0]   off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;
    logic [31:0]     nbits;
    logic            sign_bit;
    logic            ext_bit;

    assign shifted = XLEN'({beat1, beat0} >> {off, 3'b000});
    assign nbits   = {28'd0, ld_size(funct3)} << 3;

    always_comb begin
        sign_bit = 1'b0;
        case (ld_size(funct3))
            4'd1:    sign_bit = shifted[7];
            4'd2:    sign_bit = shifted[15];
            4'd4:    sign_bit = shifted[31];
            default: sign_bit = shifted[XLEN-1];
        endcase
    end

    assign ext_bit = sign_bit & ~funct3[2];

    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_bit
            assign result[gi] = (gi < nbits) ? shifted[gi] : ext_bit;
        end
    endgenerate

endmodule

// File: rtl/ld_align_unit.sv
// Sequential load unit: one load per handshake, word-aligned bus reads, extended result.
// Define LD_ALIGN_MISALIGN_EN to split word-crossing loads into two beats; otherwise they fault.
module ld_align_unit
    import ld_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_fault
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NB - 1);
    localparam logic [ADDR_W-1:0] NB_STEP  = ADDR_W'(NB);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   beat1_q, beat1_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] aligned;
    logic [XLEN-1:0]   ext_result;

    assign aligned = addr_q & ~OFF_MASK;

`ifdef LD_ALIGN_MISALIGN_EN
    logic split_cur;
    assign split_cur = ld_split(int'(addr_q[OW-1:0]), funct3_q, NB);
`else
    logic req_split;
    assign req_split = ld_split(int'(req_addr[OW-1:0]), req_funct3, NB);
`endif

    ld_extract #(
        .XLEN (XLEN),
        .OW   (OW)
    ) u_extract (
        .beat0  (beat0_q),
        .beat1  (beat1_q),
        .off    (addr_q[OW-1:0]),
        .funct3 (funct3_q),
        .result (ext_result)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        funct3_d      = funct3_q;
        beat0_d       = beat0_q;
        beat1_d       = beat1_q;
        fault_d       = fault_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        rsp_valid     = 1'b0;
        rsp_fault     = 1'b0;
        rsp_data      = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    if (ld_illegal(req_funct3, XLEN)) begin
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end
`ifndef LD_ALIGN_MISALIGN_EN
                    else if (req_split) begin
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                    else begin
                        fault_d = 1'b0;
                        state_d = ST_ISSUE0;
                    end
                end
            end
            ST_ISSUE0: begin
                mem_req_valid = 1'b1;
                mem_addr      = aligned;
                if (mem_req_ready) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (mem_rsp_valid) begin
                    beat0_d = mem_rdata;
`ifdef LD_ALIGN_MISALIGN_EN
                    state_d = split_cur ? ST_ISSUE1 : ST_RESP;
`else
                    state_d = ST_RESP;
`endif
                end
            end
`ifdef LD_ALIGN_MISALIGN_EN
            ST_ISSUE1: begin
                // Second beat wraps to address 0 past the top of the address space.
                mem_req_valid = 1'b1;
                mem_addr      = aligned + NB_STEP;
                if (mem_req_ready) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (mem_rsp_valid) begin
                    beat1_d = mem_rdata;
                    state_d = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_fault = fault_q;
                rsp_data  = fault_q ? '0 : ext_result;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            beat0_q  <= '0;
            beat1_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            beat0_q  <= beat0_d;
            beat1_q  <= beat1_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_ld_align_unit.sv
// Self-checking bench for ld_align_unit (XLEN=32): directed literal cases plus randomized loads
// against a byte-window reference model; honours LD_ALIGN_MISALIGN_EN.
module tb_ld_align_unit;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int NB     = XLEN / 8;
`ifdef LD_ALIGN_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_fault;

    always #5 clk = ~clk;

    ld_align_unit #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_funct3    (req_funct3),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_fault     (rsp_fault)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:255];
    int fire_cnt    = 0;
    bit late_pulse  = 1'b0;
    bit spurious_en = 1'b0;
    int ready_mode  = 0;   // 0 always ready, 1 random
    int delay_mode  = 0;   // 0 zero-wait, 1 random 0..3, 2 withheld
    int rsp_mode    = 0;   // 0 always ready, 1 random, 2 held low

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          nreq;
        int          fire_base;
        logic [31:0] addr;
        logic [2:0]  f3;
    } exp_t;
    exp_t exp_q[$];
    int txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem[a[9:2]] = v;
    endtask

    // Reference: take the little-endian byte window starting at addr, keep S bytes, extend.
    function automatic void model(input logic [31:0] a, input logic [2:0] f3,
                                  output logic [31:0] d, output logic flt, output int nreq);
        int          sz;
        int          off;
        logic        illegal;
        logic        split;
        logic [31:0] al;
        logic [63:0] win;
        logic [63:0] mask;
        sz      = 1 << f3[1:0];
        off     = int'(a % NB);
        illegal = (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110);
        split   = (off + sz) > NB;
        if (illegal || (split && !MIS)) begin
            d    = '0;
            flt  = 1'b1;
            nreq = 0;
        end else begin
            al   = a - 32'(off);
            win  = {split ? mem_word(al + 32'(NB)) : 32'd0, mem_word(al)};
            win  = win >> (8 * off);
            mask = (64'd1 << (8 * sz)) - 64'd1;
            win  = win & mask;
            if (!f3[2] && win[8*sz-1]) win = win | ~mask;
            d    = win[31:0];
            flt  = 1'b0;
            nreq = split ? 2 : 1;
        end
    endfunction

    // Memory-side bus: accepts requests, returns one response per request in order.
    initial begin
        logic [31:0] pend_addr[$];
        int          pend_time[$];
        int          cyc;
        bit          fire;
        bit          rst_now;
        logic [31:0] faddr;
        cyc = 0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            rst_now = rst;
            fire    = mem_req_valid && mem_req_ready && !rst;
            faddr   = mem_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (rst_now) begin
                pend_addr.delete();
                pend_time.delete();
            end
            if (fire) begin
                fire_cnt++;
                pend_addr.push_back(faddr);
                case (delay_mode)
                    0:       pend_time.push_back(cyc);
                    1:       pend_time.push_back(cyc + int'($urandom_range(0, 3)));
                    default: pend_time.push_back(cyc + 1000);
                endcase
            end
            mem_rdata     = $urandom;
            mem_rsp_valid = 1'b0;
            if (late_pulse) begin
                mem_rsp_valid = 1'b1;
                late_pulse    = 1'b0;
            end else if (pend_addr.size() != 0 && pend_time[0] <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = mem_word(pend_addr.pop_front());
                void'(pend_time.pop_front());
            end else if (spurious_en && pend_addr.size() == 0 && $urandom_range(0, 7) == 0) begin
                mem_rsp_valid = 1'b1;
            end
            mem_req_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Compare process: every cycle the result is presented it must match the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_fault", 32'(rsp_fault), 32'(e.fault));
                    if (rsp_ready) begin
                        chk("bus_reads", 32'(fire_cnt - e.fire_base), 32'(e.nreq));
                        $display("txn %0d: addr=%08h f3=%0d data=%08h fault=%0d reads=%0d",
                                 txn, e.addr, e.f3, rsp_data, rsp_fault, fire_cnt - e.fire_base);
                        txn++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue_load(input logic [31:0] a, input logic [2:0] f3, output bit ok);
        exp_t e;
        ok = 1'b0;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_addr   = a;
        req_funct3 = f3;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            model(a, f3, e.data, e.fault, e.nreq);
            e.fire_base = fire_cnt;
            e.addr      = a;
            e.f3        = f3;
            exp_q.push_back(e);
        end else begin
            chk("req_accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] exp_d, input logic exp_f, input int exp_lat,
                            input int exp_nreq, input int hold);
        bit ok;
        int lat;
        int base;
        base = fire_cnt;
        issue_load(a, f3, ok);
        for (lat = 1; lat <= 50; lat++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_data"}, rsp_data, exp_d);
        chk({name, "_fault"}, 32'(rsp_fault), 32'(exp_f));
        chk({name, "_reads"}, 32'(fire_cnt - base), 32'(exp_nreq));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, "_hold_data"}, rsp_data, exp_d);
        end
        rsp_mode = 0;
    endtask

    initial begin
        bit ok;
        int base;
        logic [31:0] a;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        set_word(32'h1000, 32'h8000_0000);
        directed("lb_sign", 32'h1003, 3'b000, 32'hFFFF_FF80, 1'b0, 3, 1, 0);
        set_word(32'h2000, 32'hBEEF_0000);
        directed("lhu", 32'h2002, 3'b101, 32'h0000_BEEF, 1'b0, 3, 1, 0);
        directed("lh", 32'h2002, 3'b001, 32'hFFFF_BEEF, 1'b0, 3, 1, 0);
        set_word(32'h3000, 32'h00AB_CD00);
        directed("lh_off1", 32'h3001, 3'b001, 32'hFFFF_ABCD, 1'b0, 3, 1, 0);
        directed("lbu_off1", 32'h3001, 3'b100, 32'h0000_00CD, 1'b0, 3, 1, 0);
        set_word(32'h4000, 32'h1234_5678);
        directed("lw", 32'h4000, 3'b010, 32'h1234_5678, 1'b0, 3, 1, 0);

        set_word(32'h1000, 32'h3322_ABCD);
        set_word(32'h1004, 32'h9876_5544);
        directed("lw_split", 32'h1002, 3'b010, MIS ? 32'h5544_3322 : 32'h0,
                 MIS ? 1'b0 : 1'b1, MIS ? 5 : 1, MIS ? 2 : 0, 0);
        set_word(32'hFFFF_FFFC, 32'hAABB_0000);
        set_word(32'h0000_0000, 32'h0000_CCDD);
        directed("lw_wrap", 32'hFFFF_FFFE, 3'b010, MIS ? 32'hCCDD_AABB : 32'h0,
                 MIS ? 1'b0 : 1'b1, MIS ? 5 : 1, MIS ? 2 : 0, 0);

        directed("ld_illegal", 32'h4000, 3'b011, 32'h0, 1'b1, 1, 0, 0);
        directed("lwu_illegal", 32'h4000, 3'b110, 32'h0, 1'b1, 1, 0, 0);
        directed("f3_111", 32'h4000, 3'b111, 32'h0, 1'b1, 1, 0, 0);

        set_word(32'h8000, 32'hF000_0001);
        rsp_mode = 2;
        directed("lw_stall", 32'h8000, 3'b010, 32'hF000_0001, 1'b0, 3, 1, 5);

        // Reset while the unit waits for a read that then arrives late.
        delay_mode = 2;
        base = fire_cnt;
        issue_load(32'h4000, 3'b010, ok);
        for (int n = 0; n < 20 && fire_cnt == base; n++) @(negedge clk);
        chk("rst_read_issued", 32'(fire_cnt - base), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        late_pulse = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_late_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_late_req_ready", 32'(req_ready), 32'd1);
        end
        delay_mode = 0;

        ready_mode  = 1;
        delay_mode  = 1;
        rsp_mode    = 1;
        spurious_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           a = 32'($urandom_range(0, 1023));
            issue_load(a, 3'($urandom_range(0, 7)), ok);
        end
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
